// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its byte packer.
package prog_loader_pkg;

  localparam int unsigned CpuWordW  = 32;
  localparam int unsigned ByteLanes = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StRun    = 2'd2,
    StHalted = 2'd3
  } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles host bytes little-endian into CPU words; word_valid_o pulses one
// cycle after the final byte lane of a word is accepted.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                byte_en_i,
  input  logic [7:0]          byte_data_i,
  output logic                last_lane_o,
  output logic                word_valid_o,
  output logic [CpuWordW-1:0] word_data_o
);

  localparam int unsigned LaneW = $clog2(ByteLanes);
  localparam int unsigned AccW  = CpuWordW - 8;

  logic [LaneW-1:0]    lane_q, lane_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic                word_valid_q, word_valid_d;
  logic [CpuWordW-1:0] word_data_q, word_data_d;

  assign last_lane_o  = (lane_q == LaneW'(ByteLanes - 1));
  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_data_q;

  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_en_i) begin
      if (last_lane_o) begin
        // The top lane never touches the accumulator; it completes the word directly.
        lane_d       = '0;
        word_valid_d = 1'b1;
        word_data_d  = {byte_data_i, acc_q};
      end else begin
        acc_d[8*int'(lane_q) +: 8] = byte_data_i;
        lane_d                     = lane_q + LaneW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q       <= '0;
      acc_q        <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams host bytes into instruction memory, then releases the CPU from reset
// and counts its run cycles until it halts.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     load_len,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [CpuWordW-1:0] imem_wdata,
  output logic                cpu_rst,
  input  logic                halt,
  output logic                busy,
  output logic                done,
  output logic [31:0]         run_cycles
);

  localparam int unsigned LenW = ADDR_W + 1;
  localparam logic [LenW-1:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       run_q, run_d;

  logic start_take;
  logic xfer;
  logic last_lane;
  logic word_done;
  logic final_byte;

  assign start_take = start && ((state_q == StIdle) || (state_q == StHalted));
  assign xfer       = byte_valid && byte_ready;
  assign word_done  = xfer && last_lane;
  // len_q is at least 1 whenever LOAD is active, so len_q - 1 cannot underflow there.
  assign final_byte = word_done && (words_q == (len_q - LenW'(1)));

  byte_packer u_packer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (start_take),
    .byte_en_i    (xfer),
    .byte_data_i  (byte_data),
    .last_lane_o  (last_lane),
    .word_valid_o (imem_we),
    .word_data_o  (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start) state_d = (load_len == '0) ? StRun : StLoad;
      end
      StLoad: begin
        if (final_byte) state_d = StRun;
      end
      StRun: begin
        if (halt) state_d = StHalted;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == StLoad);
    busy       = (state_q == StLoad);
    done       = (state_q == StHalted);
    cpu_rst    = (state_q == StRun) || (state_q == StHalted);
  end

  always_comb begin
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    run_d   = run_q;
    if (start_take) begin
      len_d   = (load_len > MaxLen) ? MaxLen : load_len;
      words_d = '0;
      addr_d  = '0;
      run_d   = '0;
    end else begin
      if (word_done) words_d = words_q + LenW'(1);
      if (imem_we) addr_d = addr_q + ADDR_W'(1);
      if ((state_q == StRun) && (run_q != '1)) run_d = run_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      run_q   <= '0;
    end else begin
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      run_q   <= run_d;
    end
  end

  assign imem_addr  = addr_q;
  assign run_cycles = run_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 The module SHALL have port start, input, 1: load request, sampled in IDLE and HALTED only.
REQ-005 The module SHALL have port load_len, input, ADDR_W+1: number of 32-bit words to load, latched when start is taken.
REQ-006 The module SHALL have port byte_valid, input, 1: the host byte is valid.
REQ-007 The module SHALL have port byte_data, input, 8: the host byte.
REQ-008 The module SHALL have port byte_ready, output, 1: the loader accepts a byte.
REQ-009 The module SHALL have port imem_we, output, 1: instruction-memory write strobe.
REQ-010 The module SHALL have port imem_addr, output, ADDR_W: instruction-memory word address.
REQ-011 The module SHALL have port imem_wdata, output, 32: instruction-memory write word.
REQ-012 The module SHALL have port cpu_rst, output, 1: active-low reset to SingleCycleCPU.
REQ-013 The module SHALL have port halt, input, 1: halt from SingleCycleCPU.
REQ-014 The module SHALL have port busy, output, 1: state is LOAD.
REQ-015 The module SHALL have port done, output, 1: state is HALTED.
REQ-016 The module SHALL have port run_cycles, output, 32: number of cycles spent in RUN.

Function
REQ-017 The block SHALL have exactly four states: IDLE, LOAD, RUN, HALTED.
REQ-018 In IDLE or HALTED, start=1 with load_len!=0 SHALL go to LOAD, latch the clamped length, set the word address to 0 and the byte count to 0, clear run_cycles and drive cpu_rst=0.
REQ-019 In IDLE or HALTED, start=1 with load_len=0 SHALL go to RUN with no memory write.
REQ-020 load_len values above 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-021 byte_ready SHALL be 1 only in LOAD, and a byte SHALL transfer only in a cycle with byte_valid=1 and byte_ready=1.
REQ-022 Bytes SHALL assemble little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-023 imem_we SHALL pulse for exactly one cycle, the cycle after the 4th byte of a word transfers, with imem_addr and imem_wdata registered and stable in that cycle.
REQ-024 Back-to-back transfers SHALL sustain 1 byte per cycle; a word write and a transfer of the next word's byte in the same cycle are legal.
REQ-025 The word address SHALL increment after each write.
REQ-026 After the last byte of the final word transfers, byte_ready SHALL drop the next cycle and the state SHALL go to RUN in the same cycle as the final imem_we.
REQ-027 cpu_rst SHALL be 0 in IDLE and LOAD, and 1 in RUN and HALTED.
REQ-028 In RUN, run_cycles SHALL increment each cycle and saturate at 0xFFFFFFFF.
REQ-029 halt=1 in RUN SHALL go to HALTED next edge, freeze run_cycles, and keep cpu_rst=1 so the CPU state stays readable.
REQ-030 start SHALL be ignored in LOAD and RUN, and halt SHALL be ignored outside RUN.
REQ-031 byte_valid while byte_ready=0 SHALL be ignored with no data consumed.

Reset
REQ-032 rst=0 SHALL asynchronously force IDLE and set byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done and run_cycles to 0.
REQ-033 rst=0 SHALL clear the byte count, so any partially assembled word is discarded.
REQ-034 Reset asserted mid-LOAD SHALL suppress any pending imem_we.
REQ-035 After rst rises, the first start SHALL be honoured on the first clock edge.

Structure
REQ-036 A shared package SHALL hold the state enumeration, the CPU word width constant (32) and the byte-lanes-per-word constant (4).
REQ-037 One sub-module, byte_packer, SHALL perform the 4-byte little-endian assembly and emit a one-cycle word_valid.
REQ-038 The state machine, address counter and run counter SHALL reside in prog_loader.

Verification
REQ-039 load_len=2, bytes 13,00,10,00,93,00,20,00 streamed continuously -> imem_we at addr 0 with data 0x00100013, then addr 1 with data 0x00200093, then cpu_rst=1.
REQ-040 The same stream with byte_valid toggling every other cycle -> identical writes, and no byte lost or duplicated.
REQ-041 RUN for 37 cycles then halt=1 -> done=1, run_cycles=37 held, and start=1 re-enters LOAD with cpu_rst=0.
REQ-042 rst=0 after 2 bytes of a word -> no imem_we; after release a fresh load_len=1 stream writes addr 0 correctly.
REQ-043 load_len=0 -> RUN the next cycle with no imem_we, and load_len=2^ADDR_W+5 -> exactly 2^ADDR_W writes with final addr 2^ADDR_W-1.
REQ-044 start pulses during LOAD and halt pulses during LOAD -> no effect on the write sequence or state.
